// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: up to two lanes enqueued per cycle,
// one entry per cycle presented in program order to the decoder.
module inst_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid0,
  input  logic        in_valid1,
  input  logic [31:0] in_pc0,
  input  logic [31:0] in_pc1,
  input  logic [31:0] in_inst0,
  input  logic [31:0] in_inst1,
  input  logic        in_pred_taken0,
  input  logic        in_pred_taken1,
  input  logic [31:0] in_pred_target0,
  input  logic [31:0] in_pred_target1,
  input  logic        in_excp0,
  input  logic        in_excp1,
  input  logic [5:0]  in_ecode0,
  input  logic [5:0]  in_ecode1,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_pred_br_taken,
  output logic [31:0] out_pred_br_target,
  output logic        out_excp,
  output logic [5:0]  out_ecode
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = (PW+1)'(1);
  localparam logic [PW:0] TWO = (PW+1)'(2);
  localparam logic [PW:0] LIM = (PW+1)'(DEPTH - 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] target;
    logic        excp;
    logic [5:0]  ecode;
  } ent_t;

  ent_t        r_mem [DEPTH];
  logic [PW:0] r_head;
  logic [PW:0] r_tail;

  logic [PW:0] w_count;
  logic [PW:0] w_tail1;
  logic        w_enq;
  logic        w_keep1;
  logic        w_deq;
  ent_t        w_ent0;
  ent_t        w_ent1;
  ent_t        w_head;

  assign w_count = r_tail - r_head;
  assign w_tail1 = r_tail + ONE;

  // in_ready depends on registered pointers only
  assign in_ready  = (w_count <= LIM);
  assign out_valid = (w_count != '0);

  // lane1 behind a taken or faulting lane0 is wrong-path
  assign w_keep1 = in_valid1 && !in_pred_taken0 && !in_excp0;
  assign w_enq   = in_ready && in_valid0 && !flush;
  assign w_deq   = out_valid && out_ready && !flush;

  assign w_ent0 = '{pc: in_pc0, inst: in_inst0,
                    taken: in_pred_taken0,
                    target: in_pred_target0,
                    excp: in_excp0, ecode: in_ecode0};
  assign w_ent1 = '{pc: in_pc1, inst: in_inst1,
                    taken: in_pred_taken1,
                    target: in_pred_target1,
                    excp: in_excp1, ecode: in_ecode1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_tail[PW-1:0]] <= w_ent0;
        if (w_keep1) r_mem[w_tail1[PW-1:0]] <= w_ent1;
        r_tail <= r_tail + (w_keep1 ? TWO : ONE);
      end
      if (w_deq) r_head <= r_head + ONE;
    end
  end

  assign w_head = r_mem[r_head[PW-1:0]];

  assign out_pc             = w_head.pc;
  assign out_inst           = w_head.inst;
  assign out_pred_br_taken  = w_head.taken;
  assign out_pred_br_target = w_head.target;
  assign out_excp           = w_head.excp;
  assign out_ecode          = w_head.ecode;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a small program-order queue model.
module tb_inst_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid0, in_valid1;
  logic [31:0] in_pc0, in_pc1, in_inst0, in_inst1;
  logic        in_pred_taken0, in_pred_taken1;
  logic [31:0] in_pred_target0, in_pred_target1;
  logic        in_excp0, in_excp1;
  logic [5:0]  in_ecode0, in_ecode1;
  logic        in_ready, out_valid, out_ready;
  logic [31:0] out_pc, out_inst, out_pred_br_target;
  logic        out_pred_br_taken, out_excp;
  logic [5:0]  out_ecode;

  int n_err = 0;
  int n_chk = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_pc0(in_pc0), .in_pc1(in_pc1),
    .in_inst0(in_inst0), .in_inst1(in_inst1),
    .in_pred_taken0(in_pred_taken0),
    .in_pred_taken1(in_pred_taken1),
    .in_pred_target0(in_pred_target0),
    .in_pred_target1(in_pred_target1),
    .in_excp0(in_excp0), .in_excp1(in_excp1),
    .in_ecode0(in_ecode0), .in_ecode1(in_ecode1),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst),
    .out_pred_br_taken(out_pred_br_taken),
    .out_pred_br_target(out_pred_br_target),
    .out_excp(out_excp), .out_ecode(out_ecode)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    in_valid0 = 0; in_valid1 = 0;
    in_pc0 = 0; in_pc1 = 0;
    in_inst0 = 0; in_inst1 = 0;
    in_pred_taken0 = 0; in_pred_taken1 = 0;
    in_pred_target0 = 0; in_pred_target1 = 0;
    in_excp0 = 0; in_excp1 = 0;
    in_ecode0 = 0; in_ecode1 = 0;
  endtask

  task automatic setg(input logic [31:0] pc,
                      input bit two, input bit tk);
    clr();
    in_valid0 = 1;
    in_pc0 = pc;
    in_inst0 = ~pc;
    in_pred_taken0 = tk;
    in_pred_target0 = pc + 32'h40;
    in_valid1 = two;
    in_pc1 = pc + 32'd4;
    in_inst1 = ~(pc + 32'd4);
  endtask

  // one clock with model update and per-cycle checks
  task automatic cyc(output bit acc);
    bit enq, k1, deq;
    int n;
    n   = mq.size();
    enq = in_valid0 && !flush && (n <= DEPTH - 2);
    k1  = in_valid1 && !in_pred_taken0 && !in_excp0;
    deq = out_ready && (n != 0) && !flush;
    @(posedge clk); #1;
    if (flush) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(in_pc0);
      if (enq && k1) mq.push_back(in_pc1);
    end
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, mq.size() <= DEPTH - 2);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0]);
      chk("out_inst", out_inst, ~mq[0]);
    end
    acc = enq;
  endtask

  task automatic step();
    bit a;
    cyc(a);
  endtask

  initial begin
    bit acc;
    int b;
    reset = 1; flush = 0; out_ready = 0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);
    chk("rst_ecode", out_ecode, 0);
    reset = 0;

    setg(32'h1c000000, 0, 0);
    step();
    clr();
    chk("first_pc", out_pc, 32'h1c000000);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("first_pop", out_valid, 0);

    setg(32'h100, 1, 0);
    out_ready = 1;
    step();
    clr();
    chk("dual0", out_pc, 32'h100);
    step();
    chk("dual1", out_pc, 32'h104);
    step();
    out_ready = 0;

    setg(32'h100, 1, 1);
    in_pred_target0 = 32'h200;
    step();
    clr();
    chk("tk_pc", out_pc, 32'h100);
    chk("tk_taken", out_pred_br_taken, 1);
    chk("tk_target", out_pred_br_target, 32'h200);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("tk_drop", out_valid, 0);

    setg(32'h100, 1, 0);
    in_excp0 = 1;
    in_ecode0 = 6'h08;
    step();
    clr();
    chk("ex_flag", out_excp, 1);
    chk("ex_ecode", out_ecode, 6'h08);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("ex_drop", out_valid, 0);

    for (int g = 0; g < 3; g++) begin
      setg(32'h1000 + 32'(g * 8), 1, 0);
      step();
    end
    setg(32'h1018, 0, 0);
    step();
    chk("full7_ready", in_ready, 0);
    setg(32'h2000, 1, 0);
    step();
    clr();
    chk("hold_pc", out_pc, 32'h1000);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("cnt6_ready", in_ready, 1);
    setg(32'h1020, 1, 0);
    step();
    clr();
    chk("full8_ready", in_ready, 0);
    chk("full8_pc", out_pc, 32'h1004);
    out_ready = 1;
    step();
    step();
    setg(32'h1030, 1, 0);
    step();
    clr();
    out_ready = 0;
    chk("simul_ready", in_ready, 0);
    chk("simul_pc", out_pc, 32'h1010);

    out_ready = 1;
    b = 0;
    while (mq.size() != 0 && b < 24) begin
      step();
      b++;
    end
    chk("drain1", out_valid, 0);

    for (int g = 0; g < 20; g++) begin
      setg(32'h4000 + 32'(g * 8), 1, (g % 5) == 3);
      out_ready = (g % 3) != 0;
      acc = 0;
      b = 0;
      while (!acc && b < 16) begin
        cyc(acc);
        out_ready = 1;
        b++;
      end
      chk("accept", {31'b0, acc}, 1);
    end
    clr();
    out_ready = 1;
    b = 0;
    while (mq.size() != 0 && b < 40) begin
      step();
      b++;
    end
    chk("drain2", out_valid, 0);
    out_ready = 0;

    setg(32'h5000, 1, 0);
    step();
    setg(32'h5008, 1, 0);
    step();
    setg(32'h5010, 0, 0);
    step();
    setg(32'h6000, 1, 0);
    out_ready = 1;
    flush = 1;
    step();
    flush = 0;
    out_ready = 0;
    clr();
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    setg(32'h300, 0, 0);
    step();
    clr();
    chk("post_flush_pc", out_pc, 32'h300);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("post_flush_alone", out_valid, 0);

    setg(32'h7000, 1, 0);
    step();
    setg(32'h7008, 1, 0);
    flush = 1;
    reset = 1;
    @(posedge clk); #1;
    mq.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_ready", in_ready, 1);
    reset = 0;
    flush = 0;
    clr();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
